balance_seq: RTL and testbench
==============================

// Module: balance_seq
// PURPOSE
//  Top-level ride sequencer for the Segway. Drives pwr_up and en_steer into the
//  balance controller, and a piezo enable. Gates the controller on rider presence,
//  settle time, overspeed and low battery. Sits between the push-button, steer_en
//  and battery monitor on one side and the balance controller / piezo on the other.
// PARAMETERS
//  fast_sim    0    1: shrink SETTLE_VLD, TF_CLR_VLD and BEEP_DIV by 16x for simulation
//  SETTLE_VLD  256  consecutive vld pulses with rider on before RIDE is entered
//  TF_CLR_VLD  64   consecutive vld pulses with too_fast low before leaving OVERSPD
//  BEEP_DIV    2048 piezo half-period in clk cycles
//  IDLE_TO     2**24 clk cycles in IDLE with no rider before auto power-off (AUTO_OFF_EN)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous reset, active-low
//  pwr_btn      in   1  synchronised push-button level; rising edge = press
//  vld          in   1  new inertial sample strobe (1 clk wide)
//  rider_off    in   1  high when load cells show no rider
//  en_steer_req in   1  steering permitted by steer_en
//  too_fast     in   1  wheel speed above limit, from balance controller
//  batt_low     in   1  battery below threshold
//  pwr_up       out  1  enables integrator and motor speeds
//  en_steer     out  1  applies load-cell steering term
//  piezo        out  1  square-wave drive to the piezo buzzer
//  seq_state    out  3  current state encoding, for debug/LEDs
// BEHAVIOUR
//  - All outputs are registered. Reset values: pwr_up=0, en_steer=0, piezo=0, seq_state=OFF.
//  - Inputs sampled on cycle N take effect on the outputs on cycle N+1.
//  - btn_edge = pwr_btn & ~pwr_btn_q. pwr_btn_q resets to 1, so a button held
//    through reset does not produce a press.
//  - States and transitions, with priority top to bottom inside each state:
//    OFF:     pwr_up=0. btn_edge -> IDLE.
//    IDLE:    pwr_up=1, en_steer=0. btn_edge|batt_low -> OFF; ~rider_off -> SETTLE.
//    SETTLE:  pwr_up=1, en_steer=0. rider_off -> IDLE (clear count); btn_edge|batt_low -> SHUTDN;
//             vld with cnt==SETTLE_VLD-1 -> RIDE; else vld increments cnt.
//    RIDE:    pwr_up=1, en_steer=en_steer_req. rider_off -> IDLE; btn_edge|batt_low -> SHUTDN;
//             too_fast -> OVERSPD (clear count).
//    OVERSPD: en_steer=0, piezo active. rider_off -> IDLE; btn_edge|batt_low -> SHUTDN;
//             too_fast on any cycle clears cnt; vld & ~too_fast & cnt==TF_CLR_VLD-1 -> RIDE.
//    SHUTDN:  pwr_up=1 (never drop a rider), en_steer=0, piezo active. rider_off -> OFF.
//             btn_edge is ignored.
//  - Simultaneous vld and rider_off: rider_off wins, and the count is not incremented.
//  - The shared count register is 8 bits when fast_sim=0 and saturates; it is cleared on
//    every state entry.
//  - Reset asserted mid-operation returns to OFF within the same cycle (async).
//  - piezo toggles every BEEP_DIV clk cycles while active. It is held 0, with its divider
//    cleared, when inactive.
// CONFIGURATION
//  `AUTO_OFF_EN defined: a 24-bit idle timer counts clk cycles while in IDLE with
//    rider_off=1, and clears on any other condition. When it reaches IDLE_TO-1 the next
//    state is OFF.
//  `AUTO_OFF_EN undefined: no timer is instantiated; IDLE persists indefinitely.
// STRUCTURE
//  - Package balance_seq_pkg: typedef enum logic [2:0] seq_state_t
//    {OFF=0,IDLE=1,SETTLE=2,RIDE=3,OVERSPD=4,SHUTDN=5}, and localparam defaults for
//    SETTLE_VLD, TF_CLR_VLD and BEEP_DIV.
//  - One sub-module, piezo_gen(clk,rst_n,en,piezo), holding the BEEP_DIV divider
//    and the toggle flop.
//  - The state register, next-state logic, count register and edge detect live in
//    balance_seq.
// TESTING
//  1. Reset, then pwr_btn pulse -> seq_state IDLE, pwr_up=1 one cycle after the edge.
//     A second pulse -> OFF.
//  2. IDLE, rider_off=0, en_steer_req=1, 256 vld pulses -> RIDE after the 256th, en_steer=1.
//     rider_off=1 at vld #100 -> IDLE, and the count restarts on re-entry.
//  3. RIDE, too_fast=1 -> OVERSPD, en_steer=0, piezo toggling every 2048 clks.
//     too_fast drops at vld #40 of 64 -> stays in OVERSPD. 64 clean vlds -> RIDE.
//  4. RIDE, batt_low=1 -> SHUTDN, pwr_up remains 1, btn ignored. rider_off=1 -> OFF, pwr_up=0.
//  5. Same cycle vld=1 and rider_off=1 in SETTLE -> IDLE. rst_n low mid-RIDE -> all outputs 0 at once.
//  6. AUTO_OFF_EN with IDLE_TO=1000: IDLE, rider_off=1 for 1000 clks -> OFF.
//     Without the macro -> still IDLE after 10000 clks.

Source files
------------

// File: rtl/balance_seq_pkg.sv
// Shared types and default timing constants for the ride sequencer.
package balance_seq_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    IDLE    = 3'd1,
    SETTLE  = 3'd2,
    RIDE    = 3'd3,
    OVERSPD = 3'd4,
    SHUTDN  = 3'd5
  } seq_state_t;

  localparam int SETTLE_VLD_DEF = 256;
  localparam int TF_CLR_VLD_DEF = 64;
  localparam int BEEP_DIV_DEF   = 2048;
  localparam int IDLE_TO_DEF    = 2 ** 24;
  localparam int CNT_W          = 8;

  // Simulation builds shrink the long waits by 16x so runs stay short.
  function automatic int scale_time(input int val, input bit fast);
    return fast ? (val / 16) : val;
  endfunction

endpackage

// File: rtl/balance_seq_piezo_gen.sv
// Piezo square-wave generator: toggles every BEEP_DIV cycles while enabled,
// held low with the divider cleared while disabled.
module piezo_gen #(
  parameter int BEEP_DIV = 2048
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic piezo
);

  localparam int DIV_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEEP_DIV - 1);

  logic [DIV_W-1:0] div_reg;

  // Divider and toggle flop; disabling restarts the half-period from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
      piezo   <= 1'b0;
    end else if (!en) begin
      div_reg <= '0;
      piezo   <= 1'b0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
      piezo   <= ~piezo;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

endmodule

// File: rtl/balance_seq.sv
// Segway ride sequencer: gates the balance controller on rider presence,
// settle time, overspeed and low battery, and drives the piezo warning.
// Optional macro AUTO_OFF_EN adds an idle auto power-off timer (IDLE_TO).
module balance_seq
  import balance_seq_pkg::*;
#(
  parameter bit fast_sim   = 1'b0,
  parameter int SETTLE_VLD = SETTLE_VLD_DEF,
  parameter int TF_CLR_VLD = TF_CLR_VLD_DEF,
  parameter int BEEP_DIV   = BEEP_DIV_DEF
`ifdef AUTO_OFF_EN
  ,
  parameter int IDLE_TO    = IDLE_TO_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_btn,
  input  logic       vld,
  input  logic       rider_off,
  input  logic       en_steer_req,
  input  logic       too_fast,
  input  logic       batt_low,
  output logic       pwr_up,
  output logic       en_steer,
  output logic       piezo,
  output logic [2:0] seq_state
);

  localparam int SETTLE_N = scale_time(SETTLE_VLD, fast_sim);
  localparam int TF_N     = scale_time(TF_CLR_VLD, fast_sim);
  localparam int BEEP_N   = scale_time(BEEP_DIV, fast_sim);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_N - 1);
  localparam logic [CNT_W-1:0] TF_LAST     = CNT_W'(TF_N - 1);

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             btn_q_reg;
  logic             btn_edge;
  logic             stop_req;
  logic             idle_expired;
  logic             pwr_up_reg, en_steer_reg;
  logic             beep_en;

  assign btn_edge = pwr_btn & ~btn_q_reg;
  assign stop_req = btn_edge | batt_low;
  assign cnt_inc  = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;

`ifdef AUTO_OFF_EN
  logic [23:0] idle_tmr_reg;

  // Idle timer: runs only while sitting in IDLE with nobody on board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_tmr_reg <= '0;
    end else if ((state_reg == IDLE) && rider_off) begin
      idle_tmr_reg <= idle_tmr_reg + 1'b1;
    end else begin
      idle_tmr_reg <= '0;
    end
  end

  assign idle_expired = (idle_tmr_reg == 24'(IDLE_TO - 1));
`else
  assign idle_expired = 1'b0;
`endif

  // Button history resets high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q_reg <= 1'b1;
    end else begin
      btn_q_reg <= pwr_btn;
    end
  end

  // Next-state and shared count; rider_off outranks everything, including vld.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      OFF: begin
        if (btn_edge) state_next = IDLE;
      end
      IDLE: begin
        if (stop_req)          state_next = OFF;
        else if (!rider_off)   state_next = SETTLE;
        else if (idle_expired) state_next = OFF;
      end
      SETTLE: begin
        if (rider_off)     state_next = IDLE;
        else if (stop_req) state_next = SHUTDN;
        else if (vld) begin
          if (cnt_reg == SETTLE_LAST) state_next = RIDE;
          else                        cnt_next   = cnt_inc;
        end
      end
      RIDE: begin
        if (rider_off)     state_next = IDLE;
        else if (stop_req) state_next = SHUTDN;
        else if (too_fast) state_next = OVERSPD;
      end
      OVERSPD: begin
        if (rider_off)     state_next = IDLE;
        else if (stop_req) state_next = SHUTDN;
        else if (too_fast) cnt_next   = '0;
        else if (vld) begin
          if (cnt_reg == TF_LAST) state_next = RIDE;
          else                    cnt_next   = cnt_inc;
        end
      end
      SHUTDN: begin
        if (rider_off) state_next = OFF;
      end
      default: begin
        state_next = OFF;
      end
    endcase
    if (state_next != state_reg) cnt_next = '0;
  end

  // State, count and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= OFF;
      cnt_reg      <= '0;
      pwr_up_reg   <= 1'b0;
      en_steer_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pwr_up_reg   <= (state_next != OFF);
      en_steer_reg <= (state_next == RIDE) & en_steer_req;
    end
  end

  assign beep_en = (state_next == OVERSPD) || (state_next == SHUTDN);

  piezo_gen #(
    .BEEP_DIV(BEEP_N)
  ) u_piezo (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (beep_en),
    .piezo(piezo)
  );

  assign pwr_up    = pwr_up_reg;
  assign en_steer  = en_steer_reg;
  assign seq_state = state_reg;

endmodule

// File: tb/tb_balance_seq.sv
// Self-checking bench for balance_seq: randomized stimulus, behavioural model,
// expected-output queue and an independent monitor.
module tb_balance_seq;

  localparam int SV = 256;
  localparam int TV = 64;
  localparam int BD = 2048;
`ifdef AUTO_OFF_EN
  localparam int ITO = 1000;
`endif

  localparam int S_OFF = 0, S_IDLE = 1, S_SETTLE = 2, S_RIDE = 3, S_OVERSPD = 4, S_SHUTDN = 5;

  logic       clk = 1'b0;
  logic       rst_n, pwr_btn, vld, rider_off, en_steer_req, too_fast, batt_low;
  logic       pwr_up, en_steer, piezo;
  logic [2:0] seq_state;

  always #5 clk = ~clk;

  balance_seq #(
    .fast_sim(1'b0)
`ifdef AUTO_OFF_EN
    , .IDLE_TO(ITO)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwr_btn     (pwr_btn),
    .vld         (vld),
    .rider_off   (rider_off),
    .en_steer_req(en_steer_req),
    .too_fast    (too_fast),
    .batt_low    (batt_low),
    .pwr_up      (pwr_up),
    .en_steer    (en_steer),
    .piezo       (piezo),
    .seq_state   (seq_state)
  );

  typedef struct {
    int st;
    bit pu;
    bit es;
    bit pz;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: state number, shared count, idle cycles, active-beep cycles.
  int m_st = S_OFF, m_cnt = 0, m_idle = 0, m_beep = 0;
  bit m_btn_q = 1'b1;

  // Values the stimulus wants on the pins for the next cycle.
  bit b_rst = 0, b_btn = 0, b_vld = 0, b_roff = 1, b_esr = 0, b_tf = 0, b_bl = 0;

  function automatic void model_step();
    exp_t e;
    bit   edge_b, stop, expired;
    int   ns;
    if (!rst_n) begin
      m_st = S_OFF; m_cnt = 0; m_idle = 0; m_beep = 0; m_btn_q = 1'b1;
      e.st = S_OFF; e.pu = 0; e.es = 0; e.pz = 0;
      exp_q.push_back(e);
      return;
    end
    edge_b  = pwr_btn && !m_btn_q;
    m_btn_q = pwr_btn;
    stop    = edge_b || batt_low;
`ifdef AUTO_OFF_EN
    expired = (m_idle == ITO - 1);
`else
    expired = 1'b0;
`endif
    ns = m_st;
    case (m_st)
      S_OFF: if (edge_b) ns = S_IDLE;
      S_IDLE: begin
        if (stop) ns = S_OFF;
        else if (!rider_off) ns = S_SETTLE;
        else if (expired) ns = S_OFF;
      end
      S_SETTLE: begin
        if (rider_off) ns = S_IDLE;
        else if (stop) ns = S_SHUTDN;
        else if (vld) begin
          if (m_cnt == SV - 1) ns = S_RIDE;
          else m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end
      S_RIDE: begin
        if (rider_off) ns = S_IDLE;
        else if (stop) ns = S_SHUTDN;
        else if (too_fast) ns = S_OVERSPD;
      end
      S_OVERSPD: begin
        if (rider_off) ns = S_IDLE;
        else if (stop) ns = S_SHUTDN;
        else if (too_fast) m_cnt = 0;
        else if (vld) begin
          if (m_cnt == TV - 1) ns = S_RIDE;
          else m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end
      default: if (rider_off) ns = S_OFF;
    endcase
    if (ns != m_st) m_cnt = 0;
    m_idle = (m_st == S_IDLE && rider_off) ? m_idle + 1 : 0;
    if (ns == S_OVERSPD || ns == S_SHUTDN) m_beep = m_beep + 1;
    else m_beep = 0;
    e.st = ns;
    e.pu = (ns != S_OFF);
    e.es = (ns == S_RIDE) && en_steer_req;
    e.pz = ((m_beep / BD) % 2) == 1;
    m_st = ns;
    exp_q.push_back(e);
  endfunction

  // Monitor: once per cycle, just after the edge, compare against the oldest expectation.
  always begin
    exp_t got;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      n_cmp++;
      if (int'(seq_state) != got.st || pwr_up != got.pu || en_steer != got.es || piezo != got.pz) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t: got state=%0d pwr_up=%0b en_steer=%0b piezo=%0b, want state=%0d pwr_up=%0b en_steer=%0b piezo=%0b",
                 $time, seq_state, pwr_up, en_steer, piezo, got.st, got.pu, got.es, got.pz);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    rst_n = b_rst; pwr_btn = b_btn; vld = b_vld; rider_off = b_roff;
    en_steer_req = b_esr; too_fast = b_tf; batt_low = b_bl;
    model_step();
  endtask

  task automatic press();
    b_btn = 1; tick();
    b_btn = 0; tick();
  endtask

  task automatic vld_pulses(input int n, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) begin
      b_vld = 1; tick();
      b_vld = 0;
      repeat ($urandom_range(gmax, gmin)) tick();
    end
  endtask

  initial begin
    rst_n = 0; pwr_btn = 1; vld = 0; rider_off = 1; en_steer_req = 0; too_fast = 0; batt_low = 0;

    // Phase 1: button held through reset, then press on / press off.
    b_btn = 1; repeat (3) tick();
    b_rst = 1; repeat (5) tick();
    check("held_btn_no_press", seq_state, S_OFF);
    b_btn = 0; tick();
    press();
    check("press_to_idle", seq_state, S_IDLE);
    check("idle_pwr_up", pwr_up, 1);
    repeat ($urandom_range(8, 2)) tick();
    press();
    check("press_to_off", seq_state, S_OFF);
    $display("phase 1 power button: state=%0d", seq_state);

    // Phase 2: settle aborted by rider_off coinciding with vld #100, then full settle.
    press();
    b_roff = 0; b_esr = 1; repeat (2) tick();
    check("settle_entry", seq_state, S_SETTLE);
    vld_pulses(99, 0, 3);
    b_vld = 1; b_roff = 1; tick();
    b_vld = 0; tick();
    check("vld_roff_same_cycle", seq_state, S_IDLE);
    b_roff = 0; repeat (2) tick();
    vld_pulses(255, 0, 3);
    check("settle_255", seq_state, S_SETTLE);
    vld_pulses(1, 1, 1);
    check("settle_256_ride", seq_state, S_RIDE);
    check("ride_en_steer", en_steer, 1);
    for (int i = 0; i < 20; i++) begin
      b_esr = 1'($urandom); tick();
    end
    b_esr = 1; tick();
    $display("phase 2 settle: state=%0d en_steer=%0b", seq_state, en_steer);

    // Phase 3: overspeed, too_fast during vld #40 restarts the clear count.
    b_tf = 1; repeat (3) tick();
    b_tf = 0;
    check("overspd_entry", seq_state, S_OVERSPD);
    check("overspd_en_steer", en_steer, 0);
    vld_pulses(39, 20, 60);
    b_vld = 1; b_tf = 1; tick();
    b_vld = 0; b_tf = 0; tick();
    check("tf_at_vld40", seq_state, S_OVERSPD);
    vld_pulses(63, 20, 60);
    check("clear_63", seq_state, S_OVERSPD);
    vld_pulses(1, 1, 1);
    check("clear_64_ride", seq_state, S_RIDE);
    $display("phase 3 overspeed: state=%0d", seq_state);

    // Phase 4: low battery shutdown ignores the button until the rider steps off.
    b_bl = 1; tick(); tick();
    check("shutdn_entry", seq_state, S_SHUTDN);
    b_bl = 0;
    press(); repeat (10) tick(); press();
    repeat (2500) tick();
    check("shutdn_btn_ignored", seq_state, S_SHUTDN);
    check("shutdn_pwr_up", pwr_up, 1);
    b_roff = 1; repeat (2) tick();
    check("shutdn_to_off", seq_state, S_OFF);
    check("off_pwr_up", pwr_up, 0);
    $display("phase 4 shutdown: state=%0d pwr_up=%0b", seq_state, pwr_up);

    // Phase 5: asynchronous reset in the middle of a ride.
    press();
    b_roff = 0; tick();
    vld_pulses(256, 0, 0);
    tick();
    check("ride_before_reset", seq_state, S_RIDE);
    b_rst = 0; tick();
    #1;
    check("async_rst_state", seq_state, S_OFF);
    check("async_rst_outs", {pwr_up, en_steer, piezo}, 0);
    repeat (2) tick();
    b_rst = 1; tick();
    $display("phase 5 async reset: state=%0d", seq_state);

    // Phase 6: empty IDLE, auto power-off only when the option is built in.
    b_roff = 1; press();
`ifdef AUTO_OFF_EN
    repeat (ITO - 20) tick();
    check("idle_before_timeout", seq_state, S_IDLE);
    repeat (40) tick();
    check("idle_auto_off", seq_state, S_OFF);
`else
    repeat (10000) tick();
    check("idle_persists", seq_state, S_IDLE);
`endif
    $display("phase 6 idle timeout: state=%0d", seq_state);

    repeat (3) tick();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
